// File: rtl/riscv_fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: opcode constants, FSM
// states and B-type immediate helpers.
package riscv_fetch_stage_pkg;

    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } fetch_state_t;

    // 13-bit signed branch offset, bit 0 always zero.
    function automatic logic [12:0] b_imm(input logic [31:0] instr);
        return {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    endfunction

    function automatic logic is_backward_branch(input logic [31:0] instr);
        return (instr[6:0] == OPCODE_BRANCH) && instr[31];
    endfunction

endpackage

// File: rtl/riscv_fetch_stage_fifo.sv
// fetch_fifo: synchronous FIFO with clear, occupancy count and push/pop.
// Storage is not reset; only pointers and count are.
module fetch_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_clear,
    input  logic                       i_push,
    input  logic [W-1:0]               i_data,
    input  logic                       i_pop,
    output logic [W-1:0]               o_data,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    // Pointers wrap explicitly so any DEPTH works, not just powers of two.
    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_push  = i_push && (r_count != CW'(DEPTH));
    assign w_pop   = i_pop && (r_count != '0);
    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_next(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_next(r_rd_ptr);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/riscv_fetch_stage.sv
// Pipelined instruction-fetch stage: PC, imem request issue, fetch queue, redirect flush.
// Optional static backward-taken prediction is enabled by defining FETCH_PREDICT_EN.
module riscv_fetch_stage
    import riscv_fetch_stage_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int              FQ_DEPTH  = 4,
    parameter int              MAX_OUTST = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [31:0]     if_instr,
    output logic [XLEN-1:0] if_pc,
    output logic            if_pred_taken,
    output logic [XLEN-1:0] dbg_pc
);
    localparam int CW = $clog2(FQ_DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTST + 1);
    localparam int QW = 32 + XLEN + 1;

    fetch_state_t    r_state;
    fetch_state_t    w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic [OW-1:0]   r_discard;
    logic [OW-1:0]   w_discard_nxt;
    logic [OW-1:0]   w_outst;
    logic [OW-1:0]   w_outst_nxt;
    logic [CW-1:0]   w_fq_count;
    logic [QW-1:0]   w_fq_head;
    logic [XLEN-1:0] w_tag_head;
    logic [XLEN-1:0] w_pred_target;
    logic [XLEN-1:0] w_redir_pc;
    logic            w_issue;
    logic            w_push;
    logic            w_pop;
    logic            w_pred;
    logic            w_int_redir;
    logic            w_redir;

    assign w_issue     = imem_req && imem_gnt;
    // A response is dropped while flushing or when a redirect lands the same cycle.
    assign w_push      = imem_rvalid && (r_discard == '0) && !redirect_valid;
    assign w_pop       = if_valid && if_ready;
    assign w_outst_nxt = w_outst + OW'(w_issue) - OW'(imem_rvalid);

`ifdef FETCH_PREDICT_EN
    logic [12:0] w_imm;
    assign w_imm         = b_imm(imem_rdata);
    assign w_pred        = is_backward_branch(imem_rdata);
    assign w_pred_target = w_tag_head + {{(XLEN-13){w_imm[12]}}, w_imm};
`else
    assign w_pred        = 1'b0;
    assign w_pred_target = w_tag_head;
`endif

    assign w_int_redir = w_push && w_pred;
    assign w_redir     = redirect_valid || w_int_redir;
    assign w_redir_pc  = (redirect_valid ? redirect_pc : w_pred_target) & ~XLEN'(3);

    always_comb begin
        w_discard_nxt = r_discard;
        if (w_redir)
            w_discard_nxt = w_outst_nxt;
        else if (imem_rvalid && (r_discard != '0))
            w_discard_nxt = r_discard - 1'b1;
    end

    always_comb begin
        w_state_nxt = r_state;
        imem_req    = 1'b0;
        case (r_state)
            S_BOOT:  w_state_nxt = S_RUN;
            S_RUN:   imem_req = (int'(w_fq_count) + int'(w_outst) < FQ_DEPTH) &&
                                (int'(w_outst) < MAX_OUTST);
            S_FLUSH: if (w_discard_nxt == '0) w_state_nxt = S_RUN;
            default: w_state_nxt = S_BOOT;
        endcase
        if (w_redir)
            w_state_nxt = (w_discard_nxt != '0) ? S_FLUSH : S_RUN;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_BOOT;
            r_pc      <= RESET_PC;
            r_discard <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_discard <= w_discard_nxt;
            if (w_redir)
                r_pc <= w_redir_pc;
            else if (w_issue)
                r_pc <= r_pc + XLEN'(4);
        end
    end

    // The tag FIFO occupancy is exactly the number of requests in flight.
    fetch_fifo #(.W(XLEN), .DEPTH(MAX_OUTST)) u_tag_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_clear (1'b0),
        .i_push  (w_issue),
        .i_data  (r_pc),
        .i_pop   (imem_rvalid),
        .o_data  (w_tag_head),
        .o_count (w_outst)
    );

    fetch_fifo #(.W(QW), .DEPTH(FQ_DEPTH)) u_data_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_clear (redirect_valid),
        .i_push  (w_push),
        .i_data  ({imem_rdata, w_tag_head, w_pred}),
        .i_pop   (w_pop),
        .o_data  (w_fq_head),
        .o_count (w_fq_count)
    );

    assign if_valid      = (w_fq_count != '0);
    assign if_instr      = if_valid ? w_fq_head[QW-1 -: 32] : '0;
    assign if_pc         = if_valid ? w_fq_head[XLEN:1]     : '0;
    assign if_pred_taken = if_valid && w_fq_head[0];
    assign imem_addr     = r_pc;
    assign dbg_pc        = r_pc;

endmodule

// File: tb/tb_riscv_fetch_stage.sv
// Directed bench for riscv_fetch_stage with an in-order imem model and an
// expected-PC scoreboard; expectations follow FETCH_PREDICT_EN when defined.
`timescale 1ns/1ps
module tb_riscv_fetch_stage;
    import riscv_fetch_stage_pkg::*;

`ifdef FETCH_PREDICT_EN
    localparam bit PRED_EN = 1'b1;
`else
    localparam bit PRED_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic [31:0] dbg_pc;

    riscv_fetch_stage #(.XLEN(32), .RESET_PC(32'h0), .FQ_DEPTH(4), .MAX_OUTST(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_pred_taken  (if_pred_taken),
        .dbg_pc         (dbg_pc)
    );

    always #5 clk = ~clk;

    int   vectors     = 0;
    int   miscompares = 0;
    logic beq_armed   = 1'b0;
    int   lat         = 1;
    logic gnt_en      = 1'b1;
    int   cyc         = 0;
    bit   mon_en      = 1'b0;

    logic [31:0] mq_addr [$];
    int          mq_due  [$];
    logic [31:0] exp_q   [$];

    // ROM: ADDI-style words tagged with their address; BEQ x0,x0,-16 at 0x20 when armed.
    function automatic logic [31:0] rom(input logic [31:0] a);
        if (beq_armed && a == 32'h20) return 32'hFE0008E3;
        return {a[26:2], 7'b0010011};
    endfunction

    function automatic logic exp_pred(input logic [31:0] w);
        return PRED_EN && (w[6:0] == 7'b1100011) && w[31];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic load_expect(input logic [31:0] base, input int n);
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
    endtask

    // Instruction memory: gnt follows gnt_en, responses in order after lat cycles.
    initial begin
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
            if (mq_due.size() > 0 && mq_due[0] == cyc) begin
                imem_rvalid = 1'b1;
                imem_rdata  = rom(mq_addr[0]);
                void'(mq_addr.pop_front());
                void'(mq_due.pop_front());
            end
            imem_gnt = gnt_en;
            if (rst && imem_req && imem_gnt) begin
                mq_addr.push_back(imem_addr);
                mq_due.push_back(cyc + lat);
            end
        end
    end

    // Scoreboard: every accepted entry must be the next expected PC with its ROM word.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && if_valid && if_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_entry", {32'h0, if_pc}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    check("if_pc", {32'h0, if_pc}, {32'h0, e});
                    check("if_instr", {32'h0, if_instr}, {32'h0, rom(e)});
                    check("if_pred_taken", {63'h0, if_pred_taken}, {63'h0, exp_pred(rom(e))});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          found;
        logic [31:0] held;
        rst            = 1'b0;
        if_ready       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        load_expect(32'h0, 128);

        // Reset held for three cycles
        repeat (3) step();
        check("rst_req", {63'h0, imem_req}, 64'h0);
        check("rst_addr", {32'h0, imem_addr}, 64'h0);
        check("rst_dbg_pc", {32'h0, dbg_pc}, 64'h0);
        check("rst_if_valid", {63'h0, if_valid}, 64'h0);
        check("rst_if_instr", {32'h0, if_instr}, 64'h0);
        check("rst_if_pc", {32'h0, if_pc}, 64'h0);
        check("rst_pred", {63'h0, if_pred_taken}, 64'h0);
        rst    = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        check("boot_req", {63'h0, imem_req}, 64'h0);

        for (int i = 0; i < 4; i++) begin
            step();
            check("issue_req", {63'h0, imem_req}, 64'h1);
            check("issue_addr", {32'h0, imem_addr}, 64'(4 * i));
        end
        for (int i = 0; i < 6; i++) begin
            check("stream_valid", {63'h0, if_valid}, 64'h1);
            step();
        end

        // Backpressure: queue fills to FQ_DEPTH and issue stops
        if_ready = 1'b0;
        repeat (10) step();
        check("full_valid", {63'h0, if_valid}, 64'h1);
        check("full_req", {63'h0, imem_req}, 64'h0);
        check("full_head_pc", {32'h0, if_pc}, {32'h0, exp_q[0]});
        check("full_dbg_pc", {32'h0, dbg_pc}, {32'h0, exp_q[0] + 32'd16});
        if_ready = 1'b1;
        repeat (8) step();

        // Redirect with two requests in flight at 3-cycle latency
        lat   = 3;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if (mq_due.size() == 2 && !imem_rvalid && !imem_req) found = 1'b1;
        end
        check("t4_two_outstanding", {63'h0, found}, 64'h1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h42;
        step();
        redirect_valid = 1'b0;
        load_expect(32'h40, 128);
        check("t4_valid_after_redir", {63'h0, if_valid}, 64'h0);
        check("t4_state_flush", 64'(dut.r_state), 64'(S_FLUSH));
        check("t4_dbg_pc", {32'h0, dbg_pc}, 64'h40);
        check("t4_flush_no_req", {63'h0, imem_req}, 64'h0);
        repeat (12) step();

        // Grant withheld: address must stay put while requesting
        gnt_en = 1'b0;
        for (int i = 0; i < 20 && mq_due.size() > 0; i++) step();
        step();
        held = imem_addr;
        check("stall_req", {63'h0, imem_req}, 64'h1);
        step();
        step();
        check("stall_addr_held", {32'h0, imem_addr}, {32'h0, held});
        lat    = 1;
        gnt_en = 1'b1;
        repeat (6) step();

        // Redirect in the same cycle as a response and a pop
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (imem_rvalid && if_valid && if_ready) found = 1'b1;
        end
        check("t5_coincident", {63'h0, found}, 64'h1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80;
        step();
        redirect_valid = 1'b0;
        load_expect(32'h80, 128);
        check("t5_valid_after_redir", {63'h0, if_valid}, 64'h0);
        repeat (8) step();

        // Backward branch at 0x20
        beq_armed      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h20;
        step();
        redirect_valid = 1'b0;
        exp_q.delete();
        exp_q.push_back(32'h20);
        for (int i = 0; i < 4; i++)
            exp_q.push_back((PRED_EN ? 32'h10 : 32'h24) + 32'(4 * i));
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) step();
        check("t6_drained", 64'(exp_q.size()), 64'h0);
        if_ready = 1'b0;
        mon_en   = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
